fft_radix2_iter: RTL and testbench

- Parametrised iterative radix-2 decimation-in-time FFT for power-of-two sizes N = 8..64.
- Successor to the fixed 8-point parallel block: one complex sample per cycle in and out over valid/ready streams, plus in-place butterfly compute over log2(N) stages.
- Adds per-frame optional stage scaling and a sticky overflow flag.
- Sits between the sample capture front-end and the spectral post-processing logic.

---
 rtl/fft_pkg.sv | 80 ++++++++
 rtl/fft_radix2_iter_butterfly.sv | 53 +++++
 rtl/fft_radix2_iter.sv | 165 ++++++++++++++++
 tb/tb_fft_radix2_iter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT.
package fft_pkg;

  localparam int unsigned CplxW = 32;

  typedef struct packed {
    logic signed [CplxW-1:0] re;
    logic signed [CplxW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {StLoad, StCompute, StUnload} fft_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [5:0] bitrev(input logic [5:0] v, input int unsigned width);
    logic [5:0] r;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < width) r[3'(i)] = v[3'(width - 1 - i)];
    end
    return r;
  endfunction

  // cos(pi*q/32) scaled by 2^30, q = 0..16; a quarter wave covers every N up to 64
  function automatic longint cos_q30(input int unsigned q);
    case (q)
      0:       return 64'sd1073741824;
      1:       return 64'sd1068571464;
      2:       return 64'sd1053110176;
      3:       return 64'sd1027506861;
      4:       return 64'sd992008094;
      5:       return 64'sd946955747;
      6:       return 64'sd892783698;
      7:       return 64'sd830013654;
      8:       return 64'sd759250125;
      9:       return 64'sd681174602;
      10:      return 64'sd596538995;
      11:      return 64'sd506158392;
      12:      return 64'sd410903207;
      13:      return 64'sd311690799;
      14:      return 64'sd209476638;
      15:      return 64'sd105245103;
      default: return 64'sd0;
    endcase
  endfunction

  // Round-half-up of a non-negative Q30 magnitude down to (tw-2) fraction bits
  function automatic longint quant(input longint v, input int unsigned tw);
    int unsigned sh;
    sh = 32 - tw;
    if (sh == 0) return v;
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  // W_n^k = cos(2*pi*k/n) - j*sin(2*pi*k/n), valid for k < n/2
  function automatic cplx_t twiddle(input int unsigned k, input int unsigned n,
                                    input int unsigned tw);
    int unsigned q;
    longint      c;
    longint      s;
    cplx_t       r;
    q = k * (64 / n);
    if (q <= 16) begin
      c = quant(cos_q30(q), tw);
      s = quant(cos_q30(16 - q), tw);
    end else begin
      c = -quant(cos_q30(32 - q), tw);
      s = quant(cos_q30(q - 16), tw);
    end
    r.re = CplxW'(c);
    r.im = CplxW'(-s);
    return r;
  endfunction

endpackage

// File: rtl/fft_radix2_iter_butterfly.sv
// Combinational radix-2 DIT butterfly: A +/- B*W with optional halving and wrap detection.
module fft_r2_butterfly #(
  parameter int unsigned W  = 16,
  parameter int unsigned TW = 16
) (
  input  logic signed [W-1:0]  a_re_i,
  input  logic signed [W-1:0]  a_im_i,
  input  logic signed [W-1:0]  b_re_i,
  input  logic signed [W-1:0]  b_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  input  logic                 scale_en_i,
  output logic signed [W-1:0]  a_re_o,
  output logic signed [W-1:0]  a_im_o,
  output logic signed [W-1:0]  b_re_o,
  output logic signed [W-1:0]  b_im_o,
  output logic                 ovf_o
);

  localparam int unsigned PW = W + TW + 1;
  localparam int unsigned SW = PW + 1;

  logic signed [PW-1:0] p_re, p_im, t_re, t_im;
  logic signed [SW-1:0] sum  [4];
  logic signed [SW-1:0] kept [4];
  logic        [W-1:0]  res  [4];
  logic        [3:0]    ov;

  assign p_re = b_re_i * w_re_i - b_im_i * w_im_i;
  assign p_im = b_re_i * w_im_i + b_im_i * w_re_i;
  assign t_re = p_re >>> (TW - 2);
  assign t_im = p_im >>> (TW - 2);

  always_comb begin
    sum[0] = a_re_i + t_re;
    sum[1] = a_im_i + t_im;
    sum[2] = a_re_i - t_re;
    sum[3] = a_im_i - t_im;
    for (int i = 0; i < 4; i++) begin
      kept[i] = scale_en_i ? (sum[i] >>> 1) : sum[i];
      res[i]  = kept[i][W-1:0];
      // Wrapped if the retained W bits no longer sign-extend back to the exact value
      ov[i]   = kept[i] != SW'($signed(res[i]));
    end
  end

  assign a_re_o = res[0];
  assign a_im_o = res[1];
  assign b_re_o = res[2];
  assign b_im_o = res[3];
  assign ovf_o  = |ov;

endmodule

// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one butterfly per cycle, natural-order
// unload over valid/ready streams.
module fft_radix2_iter
  import fft_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = 16,
  parameter int unsigned TW   = 16,
  localparam int unsigned LogN = clog2(N)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic signed [W-1:0] in_real_i,
  input  logic signed [W-1:0] in_imag_i,
  input  logic                scale_en_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic signed [W-1:0] out_real_o,
  output logic signed [W-1:0] out_imag_o,
  output logic [LogN-1:0]     out_index_o,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                ovf_o
);

  localparam int unsigned Half = N / 2;

  fft_state_e          state_q;
  logic [LogN-1:0]     cnt_q, out_idx_q;
  logic [2:0]          stage_q;
  logic                scale_q, ovf_q;
  logic signed [W-1:0] out_re_q, out_im_q;
  logic signed [W-1:0] mem_re_q [N];
  logic signed [W-1:0] mem_im_q [N];

  logic signed [TW-1:0] tw_re [Half];
  logic signed [TW-1:0] tw_im [Half];

  for (genvar k = 0; k < Half; k++) begin : g_tw
    localparam cplx_t Tw = twiddle(k, N, TW);
    assign tw_re[k] = Tw.re[TW-1:0];
    assign tw_im[k] = Tw.im[TW-1:0];
  end

  logic [LogN-1:0] span, low, idx_a, idx_b, load_addr;
  logic [LogN-2:0] tw_idx;

  // During COMPUTE cnt_q is the butterfly number j within the current stage
  always_comb begin
    span      = LogN'(1) << stage_q;
    low       = cnt_q & (span - LogN'(1));
    idx_a     = ((cnt_q >> stage_q) << (stage_q + 3'd1)) | low;
    idx_b     = idx_a | span;
    tw_idx    = (LogN-1)'(low << (3'(LogN - 1) - stage_q));
    load_addr = LogN'(bitrev(6'(cnt_q), LogN));
  end

  logic signed [W-1:0] bf_a_re, bf_a_im, bf_b_re, bf_b_im;
  logic                bf_ovf;

  fft_r2_butterfly #(
    .W  (W),
    .TW (TW)
  ) u_bfly (
    .a_re_i     (mem_re_q[idx_a]),
    .a_im_i     (mem_im_q[idx_a]),
    .b_re_i     (mem_re_q[idx_b]),
    .b_im_i     (mem_im_q[idx_b]),
    .w_re_i     (tw_re[tw_idx]),
    .w_im_i     (tw_im[tw_idx]),
    .scale_en_i (scale_q),
    .a_re_o     (bf_a_re),
    .a_im_o     (bf_a_im),
    .b_re_o     (bf_b_re),
    .b_im_o     (bf_b_im),
    .ovf_o      (bf_ovf)
  );

  always_ff @(posedge CLK) begin
    if (state_q == StLoad && in_valid_i) begin
      mem_re_q[load_addr] <= in_real_i;
      mem_im_q[load_addr] <= in_imag_i;
    end else if (state_q == StCompute) begin
      mem_re_q[idx_a] <= bf_a_re;
      mem_im_q[idx_a] <= bf_a_im;
      mem_re_q[idx_b] <= bf_b_re;
      mem_im_q[idx_b] <= bf_b_im;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StLoad;
      cnt_q     <= '0;
      stage_q   <= '0;
      scale_q   <= 1'b0;
      ovf_q     <= 1'b0;
      out_idx_q <= '0;
      out_re_q  <= '0;
      out_im_q  <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_valid_i) begin
            if (cnt_q == '0) begin
              scale_q <= scale_en_i;
              ovf_q   <= 1'b0;
            end
            if (cnt_q == LogN'(N - 1)) begin
              cnt_q   <= '0;
              state_q <= StCompute;
            end else begin
              cnt_q <= cnt_q + LogN'(1);
            end
          end
        end
        StCompute: begin
          if (bf_ovf) ovf_q <= 1'b1;
          if (cnt_q == LogN'(Half - 1)) begin
            cnt_q <= '0;
            if (stage_q == 3'(LogN - 1)) begin
              // Bin 0 was finalised earlier in the last stage, so it is safe to read now
              stage_q   <= '0;
              state_q   <= StUnload;
              out_idx_q <= '0;
              out_re_q  <= mem_re_q[0];
              out_im_q  <= mem_im_q[0];
            end else begin
              stage_q <= stage_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + LogN'(1);
          end
        end
        StUnload: begin
          if (out_ready_i) begin
            if (out_idx_q == LogN'(N - 1)) begin
              state_q   <= StLoad;
              out_idx_q <= '0;
              out_re_q  <= '0;
              out_im_q  <= '0;
            end else begin
              out_idx_q <= out_idx_q + LogN'(1);
              out_re_q  <= mem_re_q[out_idx_q + LogN'(1)];
              out_im_q  <= mem_im_q[out_idx_q + LogN'(1)];
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign in_ready_o  = state_q == StLoad;
  assign out_valid_o = state_q == StUnload;
  assign busy_o      = state_q != StLoad;
  assign out_last_o  = (state_q == StUnload) && (out_idx_q == LogN'(N - 1));
  assign out_real_o  = out_re_q;
  assign out_imag_o  = out_im_q;
  assign out_index_o = out_idx_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Directed-vector bench for fft_radix2_iter: an 8-point and a 16-point instance share one stream.
module tb_fft_radix2_iter;

  logic CLK;
  logic RST_N, in_valid, scale_en, out_ready, sel;
  logic signed [15:0] in_real, in_imag;

  logic rdy8, val8, last8, busy8, ovf8;
  logic signed [15:0] re8, im8;
  logic [2:0] idx8;
  logic rdy16, val16, last16, busy16, ovf16;
  logic signed [15:0] re16, im16;
  logic [3:0] idx16;

  logic m_rdy, m_valid, m_last, m_busy, m_ovf;
  logic signed [15:0] m_re, m_im;
  int m_idx;

  int cyc = 0;
  int n_vec, n_err, last_hs_cyc;
  int xr[64], xi[64], er[64], ei[64];
  int gr[64], gi[64], gl[64], gidx[64];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  fft_radix2_iter #(.N(8), .W(16), .TW(16)) dut8 (
    .CLK (CLK), .RST_N (RST_N),
    .in_valid_i (in_valid && !sel), .in_ready_o (rdy8),
    .in_real_i (in_real), .in_imag_i (in_imag), .scale_en_i (scale_en),
    .out_valid_o (val8), .out_ready_i (out_ready),
    .out_real_o (re8), .out_imag_o (im8), .out_index_o (idx8), .out_last_o (last8),
    .busy_o (busy8), .ovf_o (ovf8)
  );

  fft_radix2_iter #(.N(16), .W(16), .TW(16)) dut16 (
    .CLK (CLK), .RST_N (RST_N),
    .in_valid_i (in_valid && sel), .in_ready_o (rdy16),
    .in_real_i (in_real), .in_imag_i (in_imag), .scale_en_i (scale_en),
    .out_valid_o (val16), .out_ready_i (out_ready),
    .out_real_o (re16), .out_imag_o (im16), .out_index_o (idx16), .out_last_o (last16),
    .busy_o (busy16), .ovf_o (ovf16)
  );

  always_comb begin
    if (sel) begin
      m_rdy = rdy16; m_valid = val16; m_last = last16; m_busy = busy16; m_ovf = ovf16;
      m_re = re16; m_im = im16; m_idx = int'(idx16);
    end else begin
      m_rdy = rdy8; m_valid = val8; m_last = last8; m_busy = busy8; m_ovf = ovf8;
      m_re = re8; m_im = im8; m_idx = int'(idx8);
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_vecs();
    for (int i = 0; i < 64; i++) begin
      xr[i] = 0; xi[i] = 0; er[i] = 0; ei[i] = 0;
    end
  endtask

  task automatic send_frame(input int n, input logic sc);
    int   i, guard, hs_cyc;
    logic hs;
    i = 0;
    guard = 0;
    while (i < n && guard < 4 * n + 100) begin
      @(negedge CLK);
      in_valid = 1'b1;
      in_real  = 16'(xr[i]);
      in_imag  = 16'(xi[i]);
      scale_en = sc;
      hs       = m_rdy;
      hs_cyc   = cyc;
      @(posedge CLK);
      if (hs) begin
        i++;
        last_hs_cyc = hs_cyc;
      end
      guard++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    if (i < n) check_eq("load handshakes", i, n);
  endtask

  task automatic collect_frame(input int n, input int stall_bin, input int stall_n);
    int   k, guard, held, first_cyc, lat;
    logic stable, rdy_bad, busy_ok, ref_last;
    logic signed [15:0] ref_re, ref_im;
    k = 0; guard = 0; held = 0; first_cyc = -1;
    stable = 1'b1; rdy_bad = 1'b0; busy_ok = 1'b1;
    ref_re = '0; ref_im = '0; ref_last = 1'b0;
    lat = (n == 8) ? 13 : 33;
    while (k < n && guard < 2000) begin
      @(negedge CLK);
      guard++;
      if (m_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (m_rdy) rdy_bad = 1'b1;
        if (!m_busy) busy_ok = 1'b0;
      end
      if (m_valid && m_idx == stall_bin && held < stall_n) begin
        if (held == 0) begin
          ref_re = m_re; ref_im = m_im; ref_last = m_last;
        end else if (m_re !== ref_re || m_im !== ref_im || m_last !== ref_last) begin
          stable = 1'b0;
        end
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = 1'b1;
        if (m_valid) begin
          gr[k] = m_re; gi[k] = m_im; gl[k] = m_last; gidx[k] = m_idx;
          k++;
        end
      end
    end
    out_ready = 1'b1;
    check_eq("bins received", k, n);
    check_eq("latency", first_cyc - last_hs_cyc, lat);
    check_eq("in_ready during unload", rdy_bad, 0);
    check_eq("busy during unload", busy_ok, 1);
    if (stall_n > 0) begin
      check_eq("stall cycles", held, stall_n);
      check_eq("stall output stable", stable, 1);
    end
  endtask

  task automatic verify_bins(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("%s idx[%0d]", tag, k), gidx[k], k);
      check_eq($sformatf("%s re[%0d]", tag, k), gr[k], er[k]);
      check_eq($sformatf("%s im[%0d]", tag, k), gi[k], ei[k]);
      check_eq($sformatf("%s last[%0d]", tag, k), gl[k], (k == n - 1) ? 1 : 0);
    end
  endtask

  task automatic impulse8();
    clear_vecs();
    xr[0] = 100;
    for (int i = 0; i < 8; i++) er[i] = 100;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
    scale_en = 1'b0; out_ready = 1'b1; sel = 1'b0;
    n_vec = 0; n_err = 0; last_hs_cyc = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset in_ready", m_rdy, 1);
    check_eq("reset out_valid", m_valid, 0);
    check_eq("reset busy", m_busy, 0);
    check_eq("reset ovf", m_ovf, 0);
    check_eq("reset out_index", m_idx, 0);
    check_eq("reset out_last", m_last, 0);
    check_eq("reset out_real", m_re, 0);
    check_eq("reset in_ready n16", rdy16, 1);
    RST_N = 1'b1;

    impulse8();
    send_frame(8, 1'b0);
    collect_frame(8, -1, 0);
    verify_bins(8, "impulse");
    check_eq("impulse ovf", m_ovf, 0);

    clear_vecs();
    xr[1] = 100;
    er[0] = 100; er[1] = 70;  er[2] = 0;    er[3] = -71;
    er[4] = -100; er[5] = -70; er[6] = 0;   er[7] = 71;
    ei[0] = 0;   ei[1] = -71; ei[2] = -100; ei[3] = -71;
    ei[4] = 0;   ei[5] = 71;  ei[6] = 100;  ei[7] = 71;
    send_frame(8, 1'b0);
    collect_frame(8, -1, 0);
    verify_bins(8, "delay1");

    clear_vecs();
    for (int i = 0; i < 8; i++) xr[i] = 64;
    er[0] = 512;
    send_frame(8, 1'b0);
    collect_frame(8, -1, 0);
    verify_bins(8, "dc");

    er[0] = 64;
    send_frame(8, 1'b1);
    collect_frame(8, -1, 0);
    verify_bins(8, "dc scaled");
    check_eq("dc scaled ovf", m_ovf, 0);

    clear_vecs();
    for (int i = 0; i < 8; i++) xr[i] = 30000;
    send_frame(8, 1'b0);
    collect_frame(8, -1, 0);
    check_eq("overflow ovf", m_ovf, 1);

    clear_vecs();
    send_frame(8, 1'b0);
    collect_frame(8, -1, 0);
    verify_bins(8, "zero");
    check_eq("ovf cleared", m_ovf, 0);

    impulse8();
    send_frame(8, 1'b0);
    collect_frame(8, 3, 5);
    verify_bins(8, "backpressure");

    sel = 1'b1;
    clear_vecs();
    for (int i = 0; i < 16; i++) xr[i] = (i % 2 == 1) ? -100 : 100;
    er[8] = 1600;
    send_frame(16, 1'b0);
    collect_frame(16, -1, 0);
    verify_bins(16, "alternating");
    check_eq("alternating ovf", m_ovf, 0);
    sel = 1'b0;

    impulse8();
    send_frame(8, 1'b0);
    repeat (4) @(negedge CLK);
    check_eq("busy before abort", m_busy, 1);
    RST_N = 1'b0;
    @(negedge CLK);
    check_eq("abort in_ready", m_rdy, 1);
    check_eq("abort out_valid", m_valid, 0);
    check_eq("abort busy", m_busy, 0);
    RST_N = 1'b1;
    send_frame(8, 1'b0);
    collect_frame(8, -1, 0);
    verify_bins(8, "after abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
